ds_adc_decim: RTL and testbench

Third-order CIC (sinc³) decimation filter that converts the 1-bit delta-sigma bitstream back into 16-bit unsigned PCM. It is the receive-side counterpart of `ds_dac` and uses the same single-clock, `clk_en`-qualified, `ce_out`-strobed style. Typical uses are loopback verification of `ds_dac` and front-ending an external 1-bit modulator. Output rate is the enabled-input rate divided by 2^DECIM_LOG2.

---
 rtl/ds_pkg.sv | 11 +
 rtl/ds_cic_comb.sv | 68 ++++++
 rtl/ds_adc_decim.sv | 65 ++++++
 tb/tb_ds_adc_decim.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared constants and helpers for the delta-sigma DAC/ADC pair.
// The CIC width leaves one bit above 3*log2(R) so that full scale (R^3) is representable.
package ds_pkg;

    localparam int PCM_W = 16;

    function automatic int cic_width(input int decim_log2);
        return 3 * decim_log2 + 1;
    endfunction

endpackage

// File: rtl/ds_cic_comb.sv
// Decimated comb section of the sinc^3 filter: three differentiators, saturation to PCM,
// and the registered output sample with its one-cycle valid strobe.
module ds_cic_comb
    import ds_pkg::*;
#(
    parameter int DECIM_LOG2 = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [cic_width(DECIM_LOG2)-1:0]     c0,
    output logic                                 ce_out,
    output logic [PCM_W-1:0]                     dout
);

    localparam int W     = cic_width(DECIM_LOG2);
    localparam int SHIFT = 3 * DECIM_LOG2 - PCM_W;

    logic [W-1:0]     d0_q, d0_d;
    logic [W-1:0]     d1_q, d1_d;
    logic [W-1:0]     d2_q, d2_d;
    logic [W-1:0]     c1, c2, c3;
    logic [PCM_W-1:0] sat_val;
    logic [PCM_W-1:0] dout_q, dout_d;
    logic             ce_q, ce_d;

    assign c1 = c0 - d0_q;
    assign c2 = c1 - d1_q;
    assign c3 = c2 - d2_q;

    // Only the exact full-scale value R^3 sets the top bit; it would otherwise alias to zero.
    assign sat_val = c3[W-1] ? {PCM_W{1'b1}} : PCM_W'(c3 >> SHIFT);

    always_comb begin
        d0_d   = d0_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        dout_d = dout_q;
        ce_d   = 1'b0;
        if (en) begin
            d0_d   = c0;
            d1_d   = c1;
            d2_d   = c2;
            dout_d = sat_val;
            ce_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            dout_q <= '0;
            ce_q   <= 1'b0;
        end else begin
            d0_q   <= d0_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            dout_q <= dout_d;
            ce_q   <= ce_d;
        end
    end

    assign ce_out = ce_q;
    assign dout   = dout_q;

endmodule

// File: rtl/ds_adc_decim.sv
// Sinc^3 CIC decimator turning a 1-bit delta-sigma stream into 16-bit unsigned PCM.
// Integrators and the decimation counter run at the enabled input rate; the comb runs on ticks.
module ds_adc_decim
    import ds_pkg::*;
#(
    parameter int DECIM_LOG2 = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             din,
    output logic             ce_out,
    output logic [PCM_W-1:0] dout
);

    localparam int W = cic_width(DECIM_LOG2);

    logic [W-1:0]          i1_q, i1_d;
    logic [W-1:0]          i2_q, i2_d;
    logic [W-1:0]          i3_q, i3_d;
    logic [DECIM_LOG2-1:0] dcnt_q, dcnt_d;
    logic                  tick;

    // Each integrator adds the previous stage's pre-edge value; wrap-around is harmless in a CIC.
    always_comb begin
        i1_d   = i1_q;
        i2_d   = i2_q;
        i3_d   = i3_q;
        dcnt_d = dcnt_q;
        if (clk_en) begin
            i1_d   = i1_q + W'(din);
            i2_d   = i2_q + i1_q;
            i3_d   = i3_q + i2_q;
            dcnt_d = dcnt_q + DECIM_LOG2'(1);
        end
    end

    assign tick = clk_en && (dcnt_q == {DECIM_LOG2{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q   <= '0;
            i2_q   <= '0;
            i3_q   <= '0;
            dcnt_q <= '0;
        end else begin
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            i3_q   <= i3_d;
            dcnt_q <= dcnt_d;
        end
    end

    ds_cic_comb #(
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_comb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick),
        .c0     (i3_q),
        .ce_out (ce_out),
        .dout   (dout)
    );

endmodule

// File: tb/tb_ds_adc_decim.sv
// Directed bench for the sinc^3 decimator at R=64 with hand-computed expected samples.
module tb_ds_adc_decim;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clk_en = 1'b0;
    logic        din    = 1'b0;
    logic        ce_out;
    logic [15:0] dout;

    int          compared    = 0;
    int          mismatched  = 0;
    int          enSinceCe   = 0;
    int          lastSpacing = 0;
    int          cycleCount  = 0;
    int          pattern     = 0;
    bit          enThird     = 1'b0;
    logic        altPhase    = 1'b1;
    logic [15:0] dacAcc      = '0;
    logic [15:0] sampleVal   = '0;

    ds_adc_decim #(
        .DECIM_LOG2 (6)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .din    (din),
        .ce_out (ce_out),
        .dout   (dout)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic d);
        clk_en = en;
        din    = d;
        @(posedge clk);
        #1;
        if (en && rst_n) enSinceCe++;
    endtask

    // Pattern 0: all zeros, 1: all ones, 2: alternating 1,0, 3: first-order modulator at 0x4000.
    task automatic driveCycle();
        logic        en;
        logic        d;
        logic [16:0] sum;
        en = enThird ? (cycleCount % 3 == 0) : 1'b1;
        d  = 1'($urandom);
        if (en) begin
            case (pattern)
                0: d = 1'b0;
                1: d = 1'b1;
                2: begin
                    d        = altPhase;
                    altPhase = ~altPhase;
                end
                default: begin
                    sum    = {1'b0, dacAcc} + 17'h04000;
                    d      = sum[16];
                    dacAcc = sum[15:0];
                end
            endcase
        end
        applyStimulus(en, d);
        cycleCount++;
    endtask

    task automatic waitSample(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            driveCycle();
            if (ce_out) begin
                lastSpacing = enSinceCe;
                enSinceCe   = 0;
                sampleVal   = dout;
                ok          = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s timeout: observed no ce_out, expected one within 1000 cycles", tag);
        end
    endtask

    task automatic doReset(input string tag, input int newPattern, input bit newEnThird);
        rst_n = 1'b0;
        repeat (8) applyStimulus(1'($urandom), 1'($urandom));
        checkOutput({tag, "_rst_dout"}, 32'(dout), 32'h0);
        checkOutput({tag, "_rst_ce"}, 32'(ce_out), 32'h0);
        pattern    = newPattern;
        enThird    = newEnThird;
        altPhase   = 1'b1;
        dacAcc     = '0;
        cycleCount = 0;
        rst_n      = 1'b1;
        enSinceCe  = 0;
    endtask

    initial begin
        logic [15:0] onesExp [4];
        logic        inRange;
        onesExp[0] = 16'h26C7;
        onesExp[1] = 16'hD138;
        onesExp[2] = 16'hFFFF;
        onesExp[3] = 16'hFFFF;

        $display("[TB] start");

        // Constant ones: transient C(n,3)-based samples, then saturation at exactly R^3.
        doReset("ones", 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            waitSample("ones");
            checkOutput($sformatf("ones_space%0d", k), 32'(lastSpacing), 32'd64);
            checkOutput($sformatf("ones_val%0d", k), 32'(sampleVal), 32'(onesExp[k]));
        end
        driveCycle();
        checkOutput("ones_ce_single", 32'(ce_out), 32'h0);
        waitSample("ones5");
        checkOutput("ones_val4", 32'(sampleVal), 32'hFFFF);

        doReset("zeros", 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            waitSample("zeros");
            checkOutput($sformatf("zeros_val%0d", k), 32'(sampleVal), 32'h0);
        end

        doReset("alt", 2, 1'b0);
        for (int k = 0; k < 6; k++) begin
            waitSample("alt");
            if (k >= 3) checkOutput($sformatf("alt_val%0d", k), 32'(sampleVal), 32'h8000);
        end

        doReset("dac", 3, 1'b0);
        for (int k = 0; k < 6; k++) begin
            waitSample("dac");
            if (k >= 3) begin
                inRange = (sampleVal >= 16'h3FC0) && (sampleVal <= 16'h4040);
                checkOutput($sformatf("dac_near4000_%0d_val%0h", k, sampleVal), 32'(inRange), 32'h1);
            end
        end

        // Sparse clk_en: spacing counts enabled edges only, and values are unchanged by gaps.
        doReset("sparse", 1, 1'b1);
        waitSample("sparse0");
        checkOutput("sparse_space0", 32'(lastSpacing), 32'd64);
        checkOutput("sparse_val0", 32'(sampleVal), 32'h26C7);
        waitSample("sparse1");
        checkOutput("sparse_space1", 32'(lastSpacing), 32'd64);
        checkOutput("sparse_val1", 32'(sampleVal), 32'hD138);

        repeat (60) driveCycle();
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_dout", 32'(dout), 32'h0);
        checkOutput("midrst_ce", 32'(ce_out), 32'h0);
        repeat (3) applyStimulus(1'($urandom), 1'($urandom));
        rst_n      = 1'b1;
        enSinceCe  = 0;
        cycleCount = 0;
        waitSample("postrst");
        checkOutput("postrst_space", 32'(lastSpacing), 32'd64);
        checkOutput("postrst_val", 32'(sampleVal), 32'h26C7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
